// File: rtl/sram_arbiter_rr.sv
// Round-robin SRAM command arbiter for NUM_PORTS read/write channels.
// Reads are tagged in issue order and returned through per-port credit-limited response FIFOs.
module sram_arbiter_rr #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                             sram_clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_mask,
  output logic [NUM_PORTS-1:0]             resp_valid,
  input  logic [NUM_PORTS-1:0]             resp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_data,
  output logic                             sram_addr_valid,
  input  logic                             sram_ready,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [DATA_WIDTH-1:0]            sram_data_in,
  output logic [MASK_WIDTH-1:0]            sram_write_mask,
  input  logic [DATA_WIDTH-1:0]            sram_data_out,
  input  logic                             sram_data_out_valid,
  output logic                             orphan_err
);

  localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW  = $clog2(RESP_DEPTH) + 1;
  localparam int unsigned RAW = $clog2(RESP_DEPTH);
  localparam int unsigned TAW = $clog2(TAG_DEPTH);
  localparam int unsigned TCW = TAW + 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [MASK_WIDTH-1:0] cmd_mask_q, cmd_mask_d;
  logic                  orphan_q, orphan_d;

  logic [PW-1:0]         tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]         tag_mem_d [TAG_DEPTH];
  logic [TAW-1:0]        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [TCW-1:0]        tag_cnt_q, tag_cnt_d;

  logic [CW-1:0]         credit_q [NUM_PORTS];
  logic [CW-1:0]         credit_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rmem_q [NUM_PORTS][RESP_DEPTH];
  logic [DATA_WIDTH-1:0] rmem_d [NUM_PORTS][RESP_DEPTH];
  logic [RAW-1:0]        rwr_q [NUM_PORTS];
  logic [RAW-1:0]        rwr_d [NUM_PORTS];
  logic [RAW-1:0]        rrd_q [NUM_PORTS];
  logic [RAW-1:0]        rrd_d [NUM_PORTS];
  logic [CW-1:0]         rcnt_q [NUM_PORTS];
  logic [CW-1:0]         rcnt_d [NUM_PORTS];

  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  resp_pop;
  logic                  slot_free;
  logic                  tag_full;
  logic                  tag_pop;
  logic [PW-1:0]         tag_head;
  logic                  gnt_found;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         cand;
  logic                  gnt_read;

  // Eligibility uses the pre-pop tag count so a full queue never takes a new read.
  always_comb begin
    elig      = '0;
    tag_full  = (tag_cnt_q == TCW'(TAG_DEPTH));
    slot_free = !cmd_valid_q || sram_ready;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = req_valid[p] &&
                (req_write[p] || ((credit_q[p] < CW'(RESP_DEPTH)) && !tag_full));
    end
  end

  // Search from ptr+1 upward, wrapping, for the first eligible port.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((32'(ptr_q) + k) % NUM_PORTS);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (reset || !slot_free) begin
      gnt_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
    gnt_read = gnt_found && !req_write[gnt_idx];
  end

  always_comb begin
    ptr_d       = ptr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_mask_d  = cmd_mask_q;
    orphan_d    = orphan_q;
    tag_mem_d   = tag_mem_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    credit_d    = credit_q;
    rmem_d      = rmem_q;
    rwr_d       = rwr_q;
    rrd_d       = rrd_q;
    rcnt_d      = rcnt_q;
    resp_pop    = '0;
    tag_head    = tag_mem_q[tag_rd_q];
    tag_pop     = sram_data_out_valid && (tag_cnt_q != '0);

    if (gnt_found) begin
      ptr_d       = gnt_idx;
      cmd_valid_d = 1'b1;
      cmd_addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      cmd_data_d  = req_write[gnt_idx] ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      cmd_mask_d  = req_write[gnt_idx] ? req_mask[gnt_idx*MASK_WIDTH +: MASK_WIDTH] : '0;
    end else if (sram_ready) begin
      cmd_valid_d = 1'b0;
    end

    if (gnt_read) begin
      tag_mem_d[tag_wr_q] = gnt_idx;
      tag_wr_d            = tag_wr_q + TAW'(1);
    end

    // Returns are steered to the port at the head of the in-order tag queue.
    if (tag_pop) begin
      rmem_d[tag_head][rwr_q[tag_head]] = sram_data_out;
      rwr_d[tag_head]                   = rwr_q[tag_head] + RAW'(1);
      tag_rd_d                          = tag_rd_q + TAW'(1);
    end
    if (sram_data_out_valid && (tag_cnt_q == '0)) begin
      orphan_d = 1'b1;
    end
    tag_cnt_d = tag_cnt_q + TCW'(gnt_read) - TCW'(tag_pop);

    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_pop[p] = (rcnt_q[p] != '0) && resp_ready[p];
      if (resp_pop[p]) begin
        rrd_d[p] = rrd_q[p] + RAW'(1);
      end
      credit_d[p] = credit_q[p] + CW'(gnt_read && (gnt_idx == PW'(p))) - CW'(resp_pop[p]);
      rcnt_d[p]   = rcnt_q[p] + CW'(tag_pop && (tag_head == PW'(p))) - CW'(resp_pop[p]);
    end
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      ptr_q       <= PW'(NUM_PORTS - 1);
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_mask_q  <= '0;
      orphan_q    <= 1'b0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      tag_cnt_q   <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        credit_q[p] <= '0;
        rwr_q[p]    <= '0;
        rrd_q[p]    <= '0;
        rcnt_q[p]   <= '0;
        for (int j = 0; j < RESP_DEPTH; j++) begin
          rmem_q[p][j] <= '0;
        end
      end
    end else begin
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_mask_q  <= cmd_mask_d;
      orphan_q    <= orphan_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tag_cnt_q   <= tag_cnt_d;
      tag_mem_q   <= tag_mem_d;
      credit_q    <= credit_d;
      rwr_q       <= rwr_d;
      rrd_q       <= rrd_d;
      rcnt_q      <= rcnt_d;
      rmem_q      <= rmem_d;
    end
  end

  // First-word-fall-through view of each response FIFO.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_valid[p]                      = (rcnt_q[p] != '0);
      resp_data[p*DATA_WIDTH +: DATA_WIDTH] = rmem_q[p][rrd_q[p]];
    end
  end

  assign sram_addr_valid = cmd_valid_q;
  assign sram_addr       = cmd_addr_q;
  assign sram_data_in    = cmd_data_q;
  assign sram_write_mask = cmd_mask_q;
  assign orphan_err      = orphan_q;

endmodule
